// File: rtl/store_buffer.sv
// Posted-write store buffer: queues CPU stores in a FIFO, drains them to memory in order,
// and forwards the youngest pending store data to loads of the same word.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuAddr,
  input  logic [31:0]   cpuDIn,
  output logic [31:0]   cpuDOut,
  output logic          cpuStall,
  output logic          fwdHit,
  output logic          empty,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memDIn,
  output logic          memWe,
  input  logic          memReady,
  output logic [AW-1:0] memRdAddr,
  input  logic [31:0]   memRdData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [31:0]   w_fwd_data;

  // Memory handshake: memWe is valid, memReady is ready; a write transfers on a cycle
  // where both are high, and memAddr/memDIn hold steady while valid waits for ready.
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = cpuWe && !w_full;
  assign w_pop    = !w_empty && memReady;

  assign cpuStall  = w_full;
  assign empty     = w_empty;
  assign memWe     = !w_empty;
  assign memAddr   = r_addr[r_rp];
  assign memDIn    = r_data[r_rp];
  assign memRdAddr = cpuAddr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wp] <= cpuAddr;
        r_data[r_wp] <= cpuDIn;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) &&
          (r_addr[r_rp + PW'(i)][AW-1:2] == cpuAddr[AW-1:2])) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[r_rp + PW'(i)];
      end
    end
  end

  assign fwdHit  = !cpuWe && w_hit;
  assign cpuDOut = fwdHit ? w_fwd_data : memRdData;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, ordered drain, full/stall, forwarding,
// pointer wrap and load-during-pop, checked against a bench-side queue model.
module tb_store_buffer;

  logic        clk;
  logic        rstN;
  logic        cpuWe;
  logic [31:0] cpuAddr;
  logic [31:0] cpuDIn;
  logic [31:0] cpuDOut;
  logic        cpuStall;
  logic        fwdHit;
  logic        empty;
  logic [31:0] memAddr;
  logic [31:0] memDIn;
  logic        memWe;
  logic        memReady;
  logic [31:0] memRdAddr;
  logic [31:0] memRdData;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;
  int n_drained = 0;
  logic [63:0] exp_q[$];

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .cpuWe     (cpuWe),
    .cpuAddr   (cpuAddr),
    .cpuDIn    (cpuDIn),
    .cpuDOut   (cpuDOut),
    .cpuStall  (cpuStall),
    .fwdHit    (fwdHit),
    .empty     (empty),
    .memAddr   (memAddr),
    .memDIn    (memDIn),
    .memWe     (memWe),
    .memReady  (memReady),
    .memRdAddr (memRdAddr),
    .memRdData (memRdData)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; the model predicts flags, head and pops.
  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] din,
                       input logic rdy, output logic pushed);
    logic exp_stall;
    logic exp_pop;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuDIn   = din;
    memReady = rdy;
    #1;
    exp_stall = (m_cnt == 4);
    exp_pop   = (m_cnt != 0) && rdy;
    chk("stall", 64'(cpuStall), 64'(exp_stall));
    chk("empty", 64'(empty), 64'(m_cnt == 0));
    chk("memwe", 64'(memWe), 64'(m_cnt != 0));
    if (m_cnt != 0) chk("head", {memAddr, memDIn}, exp_q[0]);
    pushed = we && !exp_stall;
    @(posedge clk);
    #1;
    if (exp_pop) begin
      void'(exp_q.pop_front());
      n_drained++;
      m_cnt--;
    end
    if (pushed) begin
      exp_q.push_back({addr, din});
      m_cnt++;
    end
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                          input logic rdy, input logic exp_hit, input logic [31:0] exp_dout);
    cpuWe     = 1'b0;
    cpuAddr   = addr;
    memRdData = rd;
    memReady  = rdy;
    #1;
    chk({tag, "_hit"}, 64'(fwdHit), 64'(exp_hit));
    chk({tag, "_dout"}, 64'(cpuDOut), 64'(exp_dout));
    chk({tag, "_rdaddr"}, 64'(memRdAddr), 64'(addr));
  endtask

  // driver sequence
  initial begin
    logic p;
    int   i;
    int   k;
    rstN = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuDIn = '0; memReady = 1'b1; memRdData = '0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // reset, idle
    cycle(1'b0, 32'h0, 32'h0, 1'b1, p);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, p);
    chk("rst_fwdhit", 64'(fwdHit), 64'd0);

    // async reset with two entries pending
    cycle(1'b1, 32'h10, 32'h1111, 1'b0, p);
    cycle(1'b1, 32'h14, 32'h2222, 1'b0, p);
    cpuWe = 1'b0; cpuAddr = 32'h10;
    #1;
    chk("pre_rst_memwe", 64'(memWe), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("async_rst_memwe", 64'(memWe), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_stall", 64'(cpuStall), 64'd0);
    chk("async_rst_fwd", 64'(fwdHit), 64'd0);
    m_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // three stores held, then drained in order
    cycle(1'b1, 32'h10, 32'hAAAA0001, 1'b0, p);
    cycle(1'b1, 32'h14, 32'hAAAA0002, 1'b0, p);
    chk("memwe_after_first", 64'(memWe), 64'd1);
    cycle(1'b1, 32'h18, 32'hAAAA0003, 1'b0, p);
    n_drained = 0;
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, p);
    chk("drain3_count", 64'(n_drained), 64'd3);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, p);

    // fill to full, fifth store held, one-cycle ready
    for (int j = 0; j < 5; j++) cycle(1'b1, 32'h40 + 32'(4 * j), 32'(j), 1'b0, p);
    chk("fifth_refused", 64'(p), 64'd0);
    cycle(1'b1, 32'h50, 32'h4, 1'b1, p);
    chk("stall_during_pop", 64'(p), 64'd0);
    cycle(1'b1, 32'h50, 32'h4, 1'b0, p);
    chk("fifth_accepted", 64'(p), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, p);
    chk("full_again", 64'(cpuStall), 64'd1);
    repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, p);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, p);

    // forwarding, youngest match wins
    cycle(1'b1, 32'h20, 32'h11, 1'b0, p);
    cycle(1'b1, 32'h24, 32'h22, 1'b0, p);
    cycle(1'b1, 32'h20, 32'h33, 1'b0, p);
    load_chk("ld20", 32'h20, 32'hBEEF, 1'b0, 1'b1, 32'h33);
    load_chk("ld23", 32'h23, 32'hBEEF, 1'b0, 1'b1, 32'h33);
    load_chk("ld24", 32'h24, 32'hBEEF, 1'b0, 1'b1, 32'h22);
    load_chk("ld28", 32'h28, 32'hDEAD, 1'b0, 1'b0, 32'hDEAD);
    cpuWe = 1'b1; cpuAddr = 32'h20;
    #1;
    chk("st_nofwd_hit", 64'(fwdHit), 64'd0);
    chk("st_nofwd_dout", 64'(cpuDOut), 64'hDEAD);
    repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, p);

    // 20 stores with toggling ready across pointer wrap
    n_drained = 0;
    i = 0;
    k = 0;
    while (i < 20 && k < 200) begin
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), k[0] == 1'b0, p);
      if (p) i++;
      k++;
    end
    chk("wrap_all_pushed", 64'(i), 64'd20);
    k = 0;
    while (m_cnt != 0 && k < 50) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, p);
      k++;
    end
    chk("wrap_all_drained", 64'(n_drained), 64'd20);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, p);

    // load forwards from entry being popped, misses next cycle
    cycle(1'b1, 32'h30, 32'h55, 1'b0, p);
    cycle(1'b1, 32'h34, 32'h66, 1'b0, p);
    load_chk("ld30_pop", 32'h30, 32'hCAFE, 1'b1, 1'b1, 32'h55);
    cycle(1'b0, 32'h30, 32'h0, 1'b1, p);
    load_chk("ld30_after", 32'h30, 32'hCAFE, 1'b0, 1'b0, 32'hCAFE);
    load_chk("ld34_after", 32'h34, 32'hCAFE, 1'b0, 1'b1, 32'h66);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, p);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU data-memory port and a data memory that may take several cycles to accept a write.
- Stores are queued in a DEPTH-entry FIFO and drained in order over a valid/ready handshake. The CPU stalls only when the queue is full.
- Loads check the queue for pending stores to the same word. On a match, the youngest matching data is forwarded; otherwise memory read data passes through.

Parameters:
- DEPTH, 4: number of queued stores; must be a power of 2, minimum 2.
- AW, 32: byte address width. Bits [1:0] are ignored for matching; accesses are whole words.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- cpuWe  in  1  store request this cycle.
- cpuAddr  in  AW  store address, or load address when cpuWe=0.
- cpuDIn  in  32  store data.
- cpuDOut  out  32  load data, combinational.
- cpuStall  out  1  queue full; a store presented this cycle is not accepted.
- fwdHit  out  1  cpuDOut is sourced from the queue.
- empty  out  1  no pending stores (fence indication).
- memAddr  out  AW  head-entry address.
- memDIn  out  32  head-entry data.
- memWe  out  1  head entry valid (write request).
- memReady  in  1  memory accepts the head this cycle.
- memRdAddr  out  AW  equals cpuAddr (load path to memory).
- memRdData  in  32  memory read data for memRdAddr.

Behaviour:
- State:
  - Entry arrays addr[DEPTH] and data[DEPTH].
  - Write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH.
- Reset (async, rstN=0):
  - wp=rp=count=0; all pending entries are discarded.
  - Outputs: memWe=0, empty=1, cpuStall=0, fwdHit=0.
  - Entry contents are don't-care. When memWe=0, memAddr and memDIn are don't-care but must not be X-propagating; drive the stale head value.
  - Reset asserted mid-handshake drops memWe immediately. The in-flight write is lost; the memory side must tolerate this.
- Combinational flags:
  - full = (count==DEPTH); cpuStall = full.
  - empty = (count==0); memWe = !empty.
  - memAddr/memDIn = entry[rp].
- Push = cpuWe && !full. On posedge: entry[wp] <= {cpuAddr, cpuDIn}; wp <= wp+1.
- Pop = memWe && memReady. On posedge: rp <= rp+1.
- count update on posedge:
  - +1 on push only; −1 on pop only; unchanged when both or neither.
- Full, same-cycle pop:
  - A push is still refused because cpuStall is computed from the current count.
  - The CPU must hold cpuWe; the store is accepted the next cycle. There is no combinational path from memReady to cpuStall.
- Empty, same-cycle push:
  - The entry appears at the head on the next cycle; memWe rises one cycle after the push. There is no bypass.
- Latency:
  - Store accepted → memWe asserted with that entry as head: minimum 1 cycle when the queue was empty.
  - Each entry holds the head until memReady is sampled high.
- Handshake rules:
  - memAddr/memDIn are stable while memWe=1 && memReady=0.
  - Writes reach memory in program order.
- Forwarding (combinational, loads only):
  - Applies when cpuWe=0.
  - Compare cpuAddr[AW-1:2] against every valid entry. Valid means within count entries starting at rp.
  - On one or more matches: fwdHit=1, cpuDOut = data of the youngest match, i.e. closest to wp−1.
  - On no match: fwdHit=0, cpuDOut = memRdData.
  - When cpuWe=1: fwdHit=0, cpuDOut = memRdData.
- Same-cycle load and pop of the matching entry:
  - The entry is still valid this cycle, so the load forwards. The pop takes effect at the edge.
- A store to an address already queued creates a new entry; there is no coalescing.
- Pointer wrap-around must be correct across arbitrarily long runs. count, not pointer equality, distinguishes full from empty.

Test Plan:
- Reset then idle, memReady=1 → empty=1, memWe=0, cpuStall=0. Assert rstN=0 while 2 entries are pending → memWe=0 and empty=1 immediately, without waiting for a clock.
- Store {0x10:0xAAAA0001}, {0x14:0xAAAA0002}, {0x18:0xAAAA0003} with memReady=0, then memReady=1 → memWe rises the cycle after the first store. The writes drain in order 0x10, 0x14, 0x18, one per cycle. empty=1 after the third pop.
- memReady=0; issue 5 back-to-back stores with DEPTH=4 → cpuStall=1 after the 4th is accepted and the 5th is held. Raise memReady for 1 cycle → stall persists that cycle; the 5th store is accepted on the next; count returns to 4.
- Queue stores {0x20:0x11}, {0x24:0x22}, {0x20:0x33} with memReady=0; load 0x20 → fwdHit=1, cpuDOut=0x33. Load 0x23 → same word, cpuDOut=0x33. Load 0x28 with memRdData=0xDEAD → fwdHit=0, cpuDOut=0xDEAD.
- 20 stores with memReady toggling 1-0-1-0 (pointer wrap) → memory receives all 20 in order with correct data; count never exceeds 4; no lost or duplicated writes.
- Queue stores {0x30:0x55} then {0x34:0x66}; load 0x30 in the cycle 0x30 is popped → fwdHit=1, cpuDOut=0x55. Load 0x30 the next cycle → fwdHit=0, cpuDOut=memRdData.
